// File: rtl/mandelbrot_fb_writer.sv
// Framebuffer writer: accepts (iteration count, address) pixels from the calc engine and writes RGB565 colors.
// Optional palette RAM lookup is compiled in with macro MANDELBROT_FB_PALETTE_EN.
module mandelbrot_fb_writer #(
  parameter int IW       = 8,
  parameter int AW       = 12,
  parameter int MAXITERS = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          init,
  input  logic [AW:0]   npix,
  output logic          done,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [IW-1:0] in_dat,
  input  logic [AW-1:0] in_adr,
  output logic          mem_cs,
  output logic          mem_we,
  output logic [AW-1:0] mem_adr,
  output logic [15:0]   mem_dat,
  input  logic          mem_ack
`ifdef MANDELBROT_FB_PALETTE_EN
  ,
  input  logic          pal_we,
  input  logic [IW-1:0] pal_adr,
  input  logic [15:0]   pal_dat
`endif
);

`ifdef MANDELBROT_FB_PALETTE_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam int PAL_DEPTH = 2 ** IW;

  logic [15:0]   pal_ram_r [PAL_DEPTH];
  logic [IW-1:0] dat_r;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [IW-1:0] IN_SET_C = IW'(MAXITERS - 1);

  // In-set pixels are black; others replicate the top iteration bits into R, G and B.
  function automatic logic [15:0] iter_color(input logic [IW-1:0] it);
    logic [15:0] c;
    if (it == IN_SET_C) begin
      c = 16'h0000;
    end else begin
      c = {it[IW-1:IW-5], it[IW-1:IW-6], it[IW-1:IW-5]};
    end
    return c;
  endfunction
`endif

  state_t        state_r;
  logic [AW:0]   cnt_r;
  logic [AW:0]   cnt_nxt_s;
  logic          init_d_r;
  logic          init_edge_s;
  logic          done_r;
  logic          in_rdy_r;
  logic          mem_cs_r;
  logic [AW-1:0] mem_adr_r;
  logic [15:0]   mem_dat_r;

  assign cnt_nxt_s   = cnt_r + (AW+1)'(1);
  assign init_edge_s = init & ~init_d_r;

  assign done    = done_r;
  assign in_rdy  = in_rdy_r;
  assign mem_cs  = mem_cs_r;
  assign mem_we  = 1'b1;
  assign mem_adr = mem_adr_r;
  assign mem_dat = mem_dat_r;

`ifdef MANDELBROT_FB_PALETTE_EN
  // Palette storage: not reset, write wins and a same-cycle lookup still sees the old word.
  always_ff @(posedge clk) begin
    if (clk_en && pal_we) begin
      pal_ram_r[pal_adr] <= pal_dat;
    end
  end
`endif

  // Frame sequencer with registered handshake and memory outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= '0;
      init_d_r  <= 1'b0;
      done_r    <= 1'b0;
      in_rdy_r  <= 1'b0;
      mem_cs_r  <= 1'b0;
      mem_adr_r <= '0;
      mem_dat_r <= 16'h0000;
`ifdef MANDELBROT_FB_PALETTE_EN
      dat_r     <= '0;
`endif
    end else if (clk_en) begin
      init_d_r <= init;
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (init_edge_s) begin
            cnt_r <= '0;
            if (npix == '0) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r  <= ST_ACCEPT;
              done_r   <= 1'b0;
              in_rdy_r <= 1'b1;
            end
          end
        end
        ST_ACCEPT: begin
          if (in_vld && in_rdy_r) begin
            in_rdy_r  <= 1'b0;
            mem_adr_r <= in_adr;
`ifdef MANDELBROT_FB_PALETTE_EN
            dat_r     <= in_dat;
            state_r   <= ST_LOOKUP;
`else
            mem_dat_r <= iter_color(in_dat);
            mem_cs_r  <= 1'b1;
            state_r   <= ST_WRITE;
`endif
          end
        end
`ifdef MANDELBROT_FB_PALETTE_EN
        ST_LOOKUP: begin
          mem_dat_r <= pal_ram_r[dat_r];
          mem_cs_r  <= 1'b1;
          state_r   <= ST_WRITE;
        end
`endif
        ST_WRITE: begin
          if (mem_ack) begin
            cnt_r    <= cnt_nxt_s;
            mem_cs_r <= 1'b0;
            if (cnt_nxt_s == npix) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r  <= ST_ACCEPT;
              in_rdy_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          done_r   <= 1'b0;
          in_rdy_r <= 1'b0;
          mem_cs_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mandelbrot_fb_writer.sv
// Randomized self-checking bench for mandelbrot_fb_writer (default build, no palette).
// A scoreboard of accepted pixels with arithmetically derived colors checks every framebuffer write.
module tb_mandelbrot_fb_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        init;
  logic [12:0] npix;
  logic        done;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  in_dat;
  logic [11:0] in_adr;
  logic        mem_cs;
  logic        mem_we;
  logic [11:0] mem_adr;
  logic [15:0] mem_dat;
  logic        mem_ack;

  int n_vec = 0;
  int n_err = 0;

  logic [27:0] exp_q[$];
  logic [7:0]  dir_dat[$];
  logic [11:0] dir_adr[$];
  logic [15:0] dir_col[$];

  mandelbrot_fb_writer dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .init(init), .npix(npix), .done(done),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat), .in_adr(in_adr),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_adr(mem_adr), .mem_dat(mem_dat), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // RGB565 of an 8-bit iteration count: 255 is in-set (black), else R=it/8, G=it/4, B=it/8.
  function automatic logic [15:0] ref_color(input int it);
    int c;
    if (it == 255) return 16'h0000;
    c = ((it / 8) * 2048) + ((it / 4) * 32) + (it / 8);
    return 16'(c);
  endfunction

  function automatic logic [30:0] outs();
    return {done, in_rdy, mem_cs, mem_adr, mem_dat};
  endfunction

  // mode: 0 init pulsed, 1 init held high, 2 init toggled randomly during the frame.
  task automatic run_frame(input int np, input int dmin, input int dmax, input int mode,
                           input int rst_at, input bit use_ce);
    int writes, dly, wwait, budget;
    bit in_write, acc_prev, ack_prev, ce_prev, finished;
    logic [30:0] snap;
    logic [27:0] wsnap, e;
    exp_q.delete();
    npix = 13'(np);
    clk_en = 1'b1;
    init = 1'b1;
    tick();
    if (mode != 1) init = 1'b0;
    check_eq("start_done", {31'd0, done}, 32'd0);
    check_eq("start_rdy", {31'd0, in_rdy}, 32'd1);
    writes = 0; in_write = 0; acc_prev = 0; ack_prev = 0; ce_prev = 1; finished = 0;
    dly = 0; wwait = 0; snap = '0; wsnap = '0;
    budget = np * 60 + 50;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (!ce_prev) begin
        check_eq("hold_ce0", {1'b0, outs()}, {1'b0, snap});
      end else begin
        if (acc_prev) check_eq("accept_to_cs", {31'd0, mem_cs}, 32'd1);
        if (ack_prev) begin
          check_eq("ack_cs_drop", {31'd0, mem_cs}, 32'd0);
          if (writes == np) check_eq("done_after_ack", {31'd0, done}, 32'd1);
          else check_eq("rdy_after_ack", {31'd0, in_rdy}, 32'd1);
        end
      end
      if (done) begin
        check_eq("done_count", writes, np);
        check_eq("done_queue", exp_q.size(), 0);
        check_eq("done_rdy", {31'd0, in_rdy}, 32'd0);
        finished = 1;
        break;
      end
      if (mem_cs) begin
        if (!in_write) begin
          in_write = 1;
          if (exp_q.size() == 0) begin
            check_eq("spurious_write", 32'd1, 32'd0);
            e = {mem_adr, mem_dat};
          end else begin
            e = exp_q.pop_front();
          end
          check_eq("wr_adr", {20'd0, mem_adr}, {20'd0, e[27:16]});
          check_eq("wr_dat", {16'd0, mem_dat}, {16'd0, e[15:0]});
          check_eq("wr_we", {31'd0, mem_we}, 32'd1);
          wsnap = {mem_adr, mem_dat};
          dly = $urandom_range(dmax, dmin);
          wwait = 0;
          if (rst_at > 0 && writes == rst_at - 1) begin
            rst = 1'b0; clk_en = 1'b0; in_vld = 1'b0; mem_ack = 1'b0;
            tick();
            check_eq("rst_cs", {31'd0, mem_cs}, 32'd0);
            check_eq("rst_done", {31'd0, done}, 32'd0);
            check_eq("rst_rdy", {31'd0, in_rdy}, 32'd0);
            rst = 1'b1; clk_en = 1'b1; init = 1'b0;
            tick();
            check_eq("rst_idle_rdy", {31'd0, in_rdy}, 32'd0);
            return;
          end
        end else begin
          check_eq("wr_stable", {4'd0, mem_adr, mem_dat}, {4'd0, wsnap});
        end
        check_eq("wr_rdy_low", {31'd0, in_rdy}, 32'd0);
      end
      snap = outs();
      clk_en = use_ce ? ($urandom_range(3, 0) != 0) : 1'b1;
      if (dir_dat.size() > 0) begin
        in_vld = 1'b1; in_dat = dir_dat[0]; in_adr = dir_adr[0];
      end else begin
        in_vld = ($urandom_range(3, 0) != 0);
        in_dat = 8'($urandom);
        in_adr = 12'($urandom);
      end
      if (mode == 2) init = 1'($urandom);
      mem_ack = mem_cs ? (wwait >= dly) : 1'($urandom);
      acc_prev = clk_en && in_vld && in_rdy;
      if (acc_prev) begin
        if (dir_dat.size() > 0) begin
          exp_q.push_back({dir_adr[0], dir_col[0]});
          void'(dir_dat.pop_front()); void'(dir_adr.pop_front()); void'(dir_col.pop_front());
        end else begin
          exp_q.push_back({in_adr, ref_color(int'(in_dat))});
        end
      end
      ack_prev = clk_en && mem_cs && mem_ack;
      if (mem_cs && clk_en) wwait++;
      if (ack_prev) begin
        writes++;
        in_write = 0;
      end
      ce_prev = clk_en;
      tick();
    end
    if (!finished) check_eq("frame_timeout", 32'd0, 32'd1);
    init = 1'b0; in_vld = 1'b0; mem_ack = 1'b0; clk_en = 1'b1;
    tick();
    check_eq("done_holds", {31'd0, done}, finished ? 32'd1 : 32'd0);
  endtask

  initial begin
    rst = 1'b0; clk_en = 1'b0; init = 1'b0; npix = 13'd0;
    in_vld = 1'b0; in_dat = 8'd0; in_adr = 12'd0; mem_ack = 1'b0;
    tick(); tick(); tick();
    check_eq("reset_done", {31'd0, done}, 32'd0);
    check_eq("reset_rdy", {31'd0, in_rdy}, 32'd0);
    check_eq("reset_cs", {31'd0, mem_cs}, 32'd0);
    check_eq("reset_adr", {20'd0, mem_adr}, 32'd0);
    check_eq("reset_dat", {16'd0, mem_dat}, 32'd0);
    check_eq("reset_we", {31'd0, mem_we}, 32'd1);
    rst = 1'b1; clk_en = 1'b1;
    tick();
    check_eq("idle_rdy", {31'd0, in_rdy}, 32'd0);

    // Directed frame: four pixels, immediate ack.
    dir_dat = '{8'h00, 8'h80, 8'hFF, 8'h10};
    dir_adr = '{12'd0, 12'd1, 12'd2, 12'd3};
    dir_col = '{16'h0000, 16'h8410, 16'h0000, 16'h1082};
    run_frame(4, 0, 0, 0, 0, 1'b0);

    // Write backpressure: ack held off for 5 cycles.
    run_frame(3, 5, 5, 0, 0, 1'b0);

    // Empty frame: straight to done, no writes.
    npix = 13'd0; init = 1'b1;
    tick();
    init = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq("np0_done", {31'd0, done}, 32'd1);
      check_eq("np0_cs", {31'd0, mem_cs}, 32'd0);
      check_eq("np0_rdy", {31'd0, in_rdy}, 32'd0);
      mem_ack = 1'($urandom);
      in_vld = 1'b1;
      tick();
    end
    mem_ack = 1'b0; in_vld = 1'b0;

    // init held high, then init toggling mid-frame: no restart.
    run_frame(6, 0, 2, 1, 0, 1'b0);
    run_frame(6, 0, 3, 2, 0, 1'b0);

    // Reset during the write of pixel 2 of 4, then a clean frame from count 0.
    run_frame(4, 0, 2, 0, 2, 1'b0);
    run_frame(4, 0, 1, 0, 0, 1'b0);

    // Random frames with clock-enable gaps and random addresses.
    for (int k = 0; k < 8; k++) begin
      run_frame($urandom_range(20, 1), 0, 3, (k % 3), 0, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
